// File: rtl/arb2_fsm.sv
// ---------------------------------------------------------------------------
// arb2_fsm -- two-requester arbiter, registered Moore FSM.
//
// req0 has fixed priority out of IDLE; an owner keeps the grant while it
// keeps requesting (no pre-emption). Every hand-over passes through one
// IDLE cycle. With MAX_HOLD != 0 an owner is forced off after MAX_HOLD
// consecutive grant cycles; the forced release pulses `timeout` during the
// following IDLE cycle and gives the next IDLE decision to the other side.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles per owner, 0 disables timeout
//   HOLD_W    width of the internal hold counter (MAX_HOLD < 2**HOLD_W)
//   CNT_W     width of the saturating grant counters
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req0      request from requester 0 (higher priority)
//   req1      request from requester 1
//   gnt0      grant to requester 0 (flop output)
//   gnt1      grant to requester 1 (flop output)
//   timeout   one-cycle registered pulse marking a forced release
//   gnt0_cnt  saturating count of IDLE->GNT0 transitions
//   gnt1_cnt  saturating count of IDLE->GNT1 transitions
// ---------------------------------------------------------------------------
module arb2_fsm #(
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             timeout,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
);

  // Encoding chosen so each grant is a state bit, i.e. straight from a flop.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam bit              TO_EN     = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic              pri1, pri1_nxt;
  logic              timeout_nxt;
  logic [CNT_W-1:0]  cnt0_nxt, cnt1_nxt;
  logic              hold_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Owner has used up its allowance on this cycle.
  assign hold_hit = TO_EN && (hold == HOLD_LAST);

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    pri1_nxt    = pri1;
    timeout_nxt = 1'b0;
    cnt0_nxt    = gnt0_cnt;
    cnt1_nxt    = gnt1_cnt;
    case (state)
      IDLE: begin
        pri1_nxt = 1'b0;
        hold_nxt = '0;
        // req0 wins unless pri1 hands the tie to req1.
        if (req0 && (!pri1 || !req1)) begin
          state_nxt = GNT0;
          cnt0_nxt  = sat_inc(gnt0_cnt);
        end else if (req1) begin
          state_nxt = GNT1;
          cnt1_nxt  = sat_inc(gnt1_cnt);
        end
      end
      GNT0: begin
        if (req0 && !hold_hit) begin
          hold_nxt = hold + HOLD_W'(1);
        end else begin
          state_nxt = IDLE;
          hold_nxt  = '0;
          if (req0) begin
            timeout_nxt = 1'b1;
            pri1_nxt    = 1'b1;
          end
        end
      end
      GNT1: begin
        if (req1 && !hold_hit) begin
          hold_nxt = hold + HOLD_W'(1);
        end else begin
          state_nxt = IDLE;
          hold_nxt  = '0;
          if (req1) begin
            timeout_nxt = 1'b1;
            pri1_nxt    = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= '0;
      pri1     <= 1'b0;
      timeout  <= 1'b0;
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold     <= hold_nxt;
      pri1     <= pri1_nxt;
      timeout  <= timeout_nxt;
      gnt0_cnt <= cnt0_nxt;
      gnt1_cnt <= cnt1_nxt;
    end
  end

  assign gnt0 = state[0];
  assign gnt1 = state[1];

endmodule

// File: tb/tb_arb2_fsm.sv
// ---------------------------------------------------------------------------
// tb_arb2_fsm -- bench for arb2_fsm.
// Three instances run side by side on one clock and reset:
//   u0: MAX_HOLD=0, CNT_W=16   (plain priority arbiter)
//   u1: MAX_HOLD=3, CNT_W=16   (timeout path)
//   u2: MAX_HOLD=0, CNT_W=2    (counter saturation)
// A behavioural model tracks owner / run length / priority per instance and
// every clock edge is compared against it, plus directed constant checks.
// ---------------------------------------------------------------------------
module tb_arb2_fsm;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] r0, r1;

  logic g0_a, g1_a, to_a;
  logic g0_b, g1_b, to_b;
  logic g0_c, g1_c, to_c;
  logic [15:0] c0_a, c1_a, c0_b, c1_b;
  logic [1:0]  c0_c, c1_c;

  int errors = 0;
  int checks = 0;

  // Model state per instance: owner -1 none / 0 / 1, run = grant cycles so far.
  int m_own[3];
  int m_run[3];
  int m_pri[3];
  int m_to[3];
  int m_c0[3];
  int m_c1[3];
  int mh[3]   = '{0, 3, 0};
  int cmax[3] = '{65535, 65535, 3};

  always #5 clk = ~clk;

  arb2_fsm #(.MAX_HOLD(0), .HOLD_W(8), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .req0(r0[0]), .req1(r1[0]),
    .gnt0(g0_a), .gnt1(g1_a), .timeout(to_a), .gnt0_cnt(c0_a), .gnt1_cnt(c1_a));

  arb2_fsm #(.MAX_HOLD(3), .HOLD_W(8), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .req0(r0[1]), .req1(r1[1]),
    .gnt0(g0_b), .gnt1(g1_b), .timeout(to_b), .gnt0_cnt(c0_b), .gnt1_cnt(c1_b));

  arb2_fsm #(.MAX_HOLD(0), .HOLD_W(8), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req0(r0[2]), .req1(r1[2]),
    .gnt0(g0_c), .gnt1(g1_c), .timeout(to_c), .gnt0_cnt(c0_c), .gnt1_cnt(c1_c));

  function automatic logic [31:0] get_g0(int i);
    case (i)
      0: return {31'b0, g0_a};
      1: return {31'b0, g0_b};
      default: return {31'b0, g0_c};
    endcase
  endfunction

  function automatic logic [31:0] get_g1(int i);
    case (i)
      0: return {31'b0, g1_a};
      1: return {31'b0, g1_b};
      default: return {31'b0, g1_c};
    endcase
  endfunction

  function automatic logic [31:0] get_to(int i);
    case (i)
      0: return {31'b0, to_a};
      1: return {31'b0, to_b};
      default: return {31'b0, to_c};
    endcase
  endfunction

  function automatic logic [31:0] get_c0(int i);
    case (i)
      0: return {16'b0, c0_a};
      1: return {16'b0, c0_b};
      default: return {30'b0, c0_c};
    endcase
  endfunction

  function automatic logic [31:0] get_c1(int i);
    case (i)
      0: return {16'b0, c1_a};
      1: return {16'b0, c1_b};
      default: return {30'b0, c1_c};
    endcase
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_own[i] = -1;
      m_run[i] = 0;
      m_pri[i] = 0;
      m_to[i]  = 0;
      m_c0[i]  = 0;
      m_c1[i]  = 0;
    end
  endtask

  // One clock edge of the arbitration rules for instance i.
  task automatic model_step(input int i);
    int k;
    bit req_k;
    if (m_own[i] < 0) begin
      m_to[i] = 0;
      if (r0[i] && (m_pri[i] == 0 || !r1[i])) begin
        m_own[i] = 0;
        m_run[i] = 1;
        m_c0[i]  = (m_c0[i] < cmax[i]) ? m_c0[i] + 1 : cmax[i];
      end else if (r1[i]) begin
        m_own[i] = 1;
        m_run[i] = 1;
        m_c1[i]  = (m_c1[i] < cmax[i]) ? m_c1[i] + 1 : cmax[i];
      end
      m_pri[i] = 0;
    end else begin
      k     = m_own[i];
      req_k = (k == 0) ? r0[i] : r1[i];
      if (!req_k) begin
        m_own[i] = -1;
        m_to[i]  = 0;
      end else if (mh[i] != 0 && m_run[i] == mh[i]) begin
        m_own[i] = -1;
        m_to[i]  = 1;
        m_pri[i] = (k == 0) ? 1 : 0;
      end else begin
        m_run[i] = m_run[i] + 1;
        m_to[i]  = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk("gnt0", i, get_g0(i), (m_own[i] == 0) ? 32'd1 : 32'd0);
      chk("gnt1", i, get_g1(i), (m_own[i] == 1) ? 32'd1 : 32'd0);
      chk("timeout", i, get_to(i), 32'(m_to[i]));
      chk("gnt0_cnt", i, get_c0(i), 32'(m_c0[i]));
      chk("gnt1_cnt", i, get_c1(i), 32'(m_c1[i]));
      chk("excl", i, get_g0(i) & get_g1(i), 32'd0);
    end
  endtask

  // Advance one clock edge, update the model, check just after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    r0 = '0;
    r1 = '0;
    model_reset();

    // Reset state
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 0, get_g0(0) | get_g1(0), 32'd0);

    // Asynchronous reset in the middle of a GNT0 tenure
    @(negedge clk) r0[0] = 1'b1;
    tick();
    tick();
    chk("gnt0_before_rst", 0, get_g0(0), 32'd1);
    #2;
    rst_n = 1'b0;
    r0[0] = 1'b0;
    #1;
    model_reset();
    chk("async_gnt0", 0, get_g0(0), 32'd0);
    chk("async_gnt1", 0, get_g1(0), 32'd0);
    chk("async_to", 0, get_to(0), 32'd0);
    chk("async_cnt0", 0, get_c0(0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    chk("idle_after_async", 0, get_g0(0) | get_g1(0), 32'd0);

    // Priority and the one-cycle gap (u0)
    @(negedge clk) begin r0[0] = 1'b1; r1[0] = 1'b1; end
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("prio_gnt0", 0, get_g0(0), 32'd1);
      chk("prio_gnt1", 0, get_g1(0), 32'd0);
    end
    @(negedge clk) r0[0] = 1'b0;
    tick();
    chk("gap", 0, get_g0(0) | get_g1(0), 32'd0);
    tick();
    chk("handover_gnt1", 0, get_g1(0), 32'd1);
    chk("prio_cnt0", 0, get_c0(0), 32'd1);
    chk("prio_cnt1", 0, get_c1(0), 32'd1);

    // No pre-emption while req1 is held
    @(negedge clk) r0[0] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("nopre_gnt1", 0, get_g1(0), 32'd1);
      chk("nopre_gnt0", 0, get_g0(0), 32'd0);
    end
    @(negedge clk) r1[0] = 1'b0;
    tick();
    chk("nopre_gap", 0, get_g0(0) | get_g1(0), 32'd0);
    tick();
    chk("nopre_gnt0_after", 0, get_g0(0), 32'd1);
    @(negedge clk) r0[0] = 1'b0;
    tick();

    // Timeout alternation with MAX_HOLD=3 (u1)
    @(negedge clk) begin r0[1] = 1'b1; r1[1] = 1'b1; end
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int n = 0; n < 3; n++) begin
        tick();
        chk((rnd % 2 == 0) ? "to_gnt0" : "to_gnt1", 1,
            (rnd % 2 == 0) ? get_g0(1) : get_g1(1), 32'd1);
        chk("to_low_in_grant", 1, get_to(1), 32'd0);
      end
      if (rnd < 3) begin
        tick();
        chk("to_gap", 1, get_g0(1) | get_g1(1), 32'd0);
        chk("to_pulse", 1, get_to(1), 32'd1);
      end
    end
    chk("to_cnt0", 1, get_c0(1), 32'd2);
    chk("to_cnt1", 1, get_c1(1), 32'd2);
    @(negedge clk) begin r0[1] = 1'b0; r1[1] = 1'b0; end
    tick();
    chk("to_no_pulse_on_drop", 1, get_to(1), 32'd0);
    tick();

    // Counter saturation with CNT_W=2 (u2)
    for (int p = 1; p <= 5; p++) begin
      @(negedge clk) r0[2] = 1'b1;
      tick();
      @(negedge clk) r0[2] = 1'b0;
      tick();
      chk("sat_cnt0", 2, get_c0(2), (p < 3) ? 32'(p) : 32'd3);
    end

    // Random stimulus on all three instances
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk) begin
        r0 = 3'($urandom);
        r1 = 3'($urandom);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
